// File: rtl/fir_pkg.sv
// Shared constants for the FIR datapath and its output stage.
package fir_pkg;
    localparam int FIR_DATA_WIDTH = 32;
    localparam int FIR_FRAME_LEN  = 600;
    localparam int FIR_TAP_NUM    = 11;
endpackage

// File: rtl/fir_fifo_ram.sv
// Storage array for the output FIFO: one synchronous write port and one asynchronous read port.
module fir_fifo_ram #(
    parameter int pWIDTH     = 33,
    parameter int pADDR_BITS = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [pADDR_BITS-1:0] waddr,
    input  logic [pWIDTH-1:0]     wdata,
    input  logic [pADDR_BITS-1:0] raddr,
    output logic [pWIDTH-1:0]     rdata
);
    logic [pWIDTH-1:0] mem [2**pADDR_BITS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/fir_out_fifo.sv
// AXI-Stream elastic buffer behind the FIR core: first-word-fall-through FIFO,
// input frame-length checker and delivered-frame counter.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int pDATA_WIDTH = FIR_DATA_WIDTH,
    parameter int pADDR_BITS  = 4,
    parameter int pFRAME_LEN  = FIR_FRAME_LEN
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    input  logic                   s_tvalid,
    input  logic [pDATA_WIDTH-1:0] s_tdata,
    input  logic                   s_tlast,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [pDATA_WIDTH-1:0] m_tdata,
    output logic                   m_tlast,
    input  logic                   m_tready,
    input  logic                   clr,
    output logic [pADDR_BITS:0]    level,
    output logic [15:0]            frame_cnt,
    output logic                   len_err
);
    localparam int PTR_W  = pADDR_BITS + 1;
    localparam int BEAT_W = $clog2(pFRAME_LEN + 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(pFRAME_LEN - 1);

    logic [pADDR_BITS:0]  wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
    logic [pDATA_WIDTH:0] rd_word;
    logic [BEAT_W-1:0]    in_beat;
    logic                 empty, full_nxt, push, pop;

    fir_fifo_ram #(
        .pWIDTH     (pDATA_WIDTH + 1),
        .pADDR_BITS (pADDR_BITS)
    ) u_ram (
        .clk   (axis_clk),
        .we    (push),
        .waddr (wr_ptr[pADDR_BITS-1:0]),
        .wdata ({s_tlast, s_tdata}),
        .raddr (rd_ptr[pADDR_BITS-1:0]),
        .rdata (rd_word)
    );

    assign empty      = (wr_ptr == rd_ptr);
    assign push       = s_tvalid && s_tready;
    assign pop        = m_tvalid && m_tready;
    assign wr_ptr_nxt = wr_ptr + PTR_W'(push);
    assign rd_ptr_nxt = rd_ptr + PTR_W'(pop);
    // Ready is registered, so it is derived from the post-update pointers.
    assign full_nxt   = (wr_ptr_nxt[pADDR_BITS] != rd_ptr_nxt[pADDR_BITS]) &&
                        (wr_ptr_nxt[pADDR_BITS-1:0] == rd_ptr_nxt[pADDR_BITS-1:0]);

    assign m_tvalid            = !empty;
    assign {m_tlast, m_tdata}  = empty ? '0 : rd_word;
    assign level               = wr_ptr - rd_ptr;

    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s_tready <= 1'b0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            s_tready <= !full_nxt;
        end
    end

    // An over-long frame is cut at pFRAME_LEN beats; the next beat starts a fresh frame.
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            in_beat   <= '0;
            len_err   <= 1'b0;
            frame_cnt <= '0;
        end else if (clr) begin
            in_beat   <= '0;
            len_err   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (push) begin
                if (s_tlast || (in_beat == BEAT_LAST)) begin
                    in_beat <= '0;
                    if (in_beat != BEAT_LAST || !s_tlast) begin
                        len_err <= 1'b1;
                    end
                end else begin
                    in_beat <= in_beat + 1'b1;
                end
            end
            if (pop && m_tlast) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_fir_out_fifo.sv
// Directed bench for fir_out_fifo: queue-based reference of FIFO contents plus
// hand-computed expectations for ready, level, frame_cnt and len_err.
module tb_fir_out_fifo;
    localparam int DEPTH = 16;
    localparam int BOUND = 400;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tlast, s_tready;
    logic [31:0] s_tdata;
    logic        m_tvalid, m_tlast, m_tready;
    logic [31:0] m_tdata;
    logic        clr;
    logic [4:0]  level;
    logic [15:0] frame_cnt;
    logic        len_err;

    logic [32:0] mq[$];
    bit          mdl_rdy;
    bit          acc;
    bit          rand_rdy;
    int          checks;
    int          errors;

    fir_out_fifo dut (
        .axis_clk   (clk),
        .axis_rst_n (rst_n),
        .s_tvalid   (s_tvalid),
        .s_tdata    (s_tdata),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tvalid   (m_tvalid),
        .m_tdata    (m_tdata),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .clr        (clr),
        .level      (level),
        .frame_cnt  (frame_cnt),
        .len_err    (len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs mid-cycle against the reference queue, then advance it.
    task automatic step();
        bit pu, po;
        logic [32:0] head, dummy;
        if (rand_rdy) m_tready = 1'($urandom_range(0, 1));
        @(negedge clk);
        head = (mq.size() != 0) ? mq[0] : 33'd0;
        chk("s_tready", s_tready, mdl_rdy);
        chk("m_tvalid", m_tvalid, mq.size() != 0);
        chk("m_word",   {m_tlast, m_tdata}, head);
        chk("level",    level, 64'(mq.size()));
        pu  = rst_n && s_tvalid && mdl_rdy;
        po  = rst_n && m_tready && (mq.size() != 0);
        acc = pu;
        if (po) dummy = mq.pop_front();
        if (pu) mq.push_back({s_tlast, s_tdata});
        mdl_rdy = rst_n && (mq.size() != DEPTH);
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = l;
        acc      = 1'b0;
        for (int n = 0; n < BOUND && !acc; n++) step();
        chk("send_accept", acc, 1'b1);
    endtask

    task automatic idle();
        s_tvalid = 1'b0;
        s_tdata  = '0;
        s_tlast  = 1'b0;
    endtask

    task automatic drain();
        idle();
        for (int n = 0; n < 4000 && mq.size() != 0; n++) step();
        chk("drain_done", mq.size() == 0, 1'b1);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b1; clr = 1'b0; m_tready = 1'b0; rand_rdy = 1'b0; mdl_rdy = 1'b0;
        idle();
        #2 rst_n = 1'b0;

        // 1: reset values, ready rises on the first edge after release
        repeat (2) step();
        chk("rst_tready",   s_tready, 1'b0);
        chk("rst_tvalid",   m_tvalid, 1'b0);
        chk("rst_tdata",    m_tdata, 32'd0);
        chk("rst_frame",    frame_cnt, 16'd0);
        chk("rst_len_err",  len_err, 1'b0);
        rst_n = 1'b1;
        #1 chk("rel_tready_before_edge", s_tready, 1'b0);
        step();
        chk("rel_tready_after_edge", s_tready, 1'b1);
        chk("rel_level", level, 5'd0);

        // 2: three-beat frame through a free-running sink
        m_tready = 1'b1;
        send(32'd1, 1'b0);
        chk("t2_fwft_valid", m_tvalid, 1'b1);
        chk("t2_fwft_data",  m_tdata, 32'd1);
        chk("t2_fwft_level", level, 5'd1);
        send(32'd2, 1'b0);
        send(32'd3, 1'b1);
        chk("t2_last_beat", m_tlast, 1'b1);
        drain();
        chk("t2_frame_cnt", frame_cnt, 16'd1);
        chk("t2_short_err", len_err, 1'b1);

        // 3: fill to 16, 17th beat held upstream, then release
        m_tready = 1'b0;
        for (int i = 0; i < 16; i++) send(32'(200 + i), 1'b0);
        chk("t3_full_ready", s_tready, 1'b0);
        chk("t3_full_level", level, 5'd16);
        s_tvalid = 1'b1; s_tdata = 32'd216; s_tlast = 1'b0;
        repeat (3) begin
            step();
            chk("t3_hold17", acc, 1'b0);
        end
        m_tready = 1'b1;
        send(32'd216, 1'b0);
        drain();
        pulse_clr();
        chk("t3_clr_frame", frame_cnt, 16'd0);
        chk("t3_clr_err",   len_err, 1'b0);

        // 4: full-length frame with random sink stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 600; i++) send(32'(1000 + i), i == 599);
        drain();
        rand_rdy = 1'b0;
        m_tready = 1'b1;
        chk("t4_frame_cnt", frame_cnt, 16'd1);
        chk("t4_len_err",   len_err, 1'b0);

        // 5: 599-beat frame, then 601-beat frame, clr with data buffered
        for (int i = 0; i < 598; i++) send(32'(3000 + i), 1'b0);
        chk("t5_598_no_err", len_err, 1'b0);
        send(32'd3598, 1'b1);
        chk("t5_599_err", len_err, 1'b1);
        drain();
        chk("t5_frame_cnt2", frame_cnt, 16'd2);
        pulse_clr();
        chk("t5_clr_err",   len_err, 1'b0);
        chk("t5_clr_frame", frame_cnt, 16'd0);
        for (int i = 0; i < 599; i++) send(32'(5000 + i), 1'b0);
        chk("t5_599_open_no_err", len_err, 1'b0);
        send(32'd5599, 1'b0);
        chk("t5_600_no_last_err", len_err, 1'b1);
        send(32'd5600, 1'b1);
        drain();
        chk("t5_long_frame_cnt", frame_cnt, 16'd1);
        m_tready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'(700 + i), 1'b0);
        idle();
        step();
        chk("t5_level3", level, 5'd3);
        pulse_clr();
        chk("t5_clr_keeps_level", level, 5'd3);
        chk("t5_clr2_err",   len_err, 1'b0);
        chk("t5_clr2_frame", frame_cnt, 16'd0);

        // 6: reset mid-frame with level 5, then a clean frame
        send(32'd703, 1'b0);
        send(32'd704, 1'b0);
        idle();
        step();
        chk("t6_level5", level, 5'd5);
        rst_n = 1'b0;
        mq.delete();
        mdl_rdy = 1'b0;
        #1;
        chk("t6_rst_tready", s_tready, 1'b0);
        chk("t6_rst_tvalid", m_tvalid, 1'b0);
        chk("t6_rst_tdata",  m_tdata, 32'd0);
        chk("t6_rst_tlast",  m_tlast, 1'b0);
        chk("t6_rst_level",  level, 5'd0);
        step();
        rst_n = 1'b1;
        step();
        m_tready = 1'b1;
        for (int i = 0; i < 600; i++) send(32'(9000 + i), i == 599);
        drain();
        chk("t6_len_err",   len_err, 1'b0);
        chk("t6_frame_cnt", frame_cnt, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
